exp_audio_decim_ser: RTL and testbench
======================================

# exp_audio_decim_ser

Output stage for the Sunsoft 5B expansion-audio path. Consumes the synth's 12-bit mixed level, which updates every CPU clock, box-car averages it down to a low sample rate, and shifts each averaged sample MSB-first to an external serial audio DAC using bit clock, data and latch strobe. Sits directly downstream of the YM2149-compatible synth. Its sample rate output is also exposed in parallel for the cartridge audio mixer.

## Interface
- DEPTH, 12: width of input level and of averaged sample.
- LOG2_DEC, 7: decimation window is 2^LOG2_DEC clocks.
- BCLK_DIV, 2: clocks per bit-clock half period (≥1).
- FRAME_BITS, 16: serial frame length (≥ DEPTH).

- clk_i  in  1  system clock, rising-edge.
- reset_n_i  in  1  synchronous, active-low reset.
- enable_i  in  1  mapper enable; low clears the decimator.
- audio_i  in  DEPTH  unsigned synth level, sampled every clock.
- sample_o  out  DEPTH  last averaged sample.
- sample_vld_o  out  1  one-clock pulse when sample_o updates.
- dac_bclk_o  out  1  serial bit clock.
- dac_data_o  out  1  serial data, MSB first.
- dac_lrck_o  out  1  latch strobe after the last bit.
- overrun_o  out  1  sticky: a pending sample was overwritten.

## Operation
- Decimator:
  - acc has width DEPTH+LOG2_DEC. cnt has width LOG2_DEC.
  - Each clock with enable_i=1: acc += audio_i and cnt += 1.
  - When cnt == 2^LOG2_DEC−1:
    - sample_o <= (acc + audio_i) >> LOG2_DEC, truncated.
    - sample_vld_o <= 1.
    - acc <= 0 and cnt <= 0.
  - The sum cannot overflow, because acc is full width.
  - enable_i=0 clears acc and cnt and suppresses sample_vld_o. sample_o holds its value. A partial window is discarded.
- Serializer FSM with states IDLE, SHIFT, LATCH:
  - Frame word is {sample, (FRAME_BITS−DEPTH) zeros}, left-justified.
  - IDLE: when sample_vld_o=1, load the frame and go to SHIFT with bit index FRAME_BITS−1.
  - SHIFT: each bit occupies 2·BCLK_DIV clocks.
    - First BCLK_DIV clocks: dac_bclk_o=0.
    - Last BCLK_DIV clocks: dac_bclk_o=1.
    - dac_data_o is stable over the whole bit.
    - After bit 0, go to LATCH.
  - LATCH: dac_lrck_o=1, dac_bclk_o=0 and dac_data_o=0 for 2·BCLK_DIV clocks. Then:
    - if pending is valid, load pending, clear it, and go to SHIFT;
    - otherwise go to IDLE.
  - IDLE outputs: dac_bclk_o, dac_data_o and dac_lrck_o are all 0.
- One-entry pending buffer:
  - sample_vld_o while not IDLE stores the sample to pending.
  - If pending is already valid, it is overwritten and overrun_o <= 1.
  - If sample_vld_o coincides with LATCH exit:
    - pending empty: the new sample loads directly into SHIFT;
    - pending full: pending loads into SHIFT, the new sample goes to pending, and there is no overrun.
- enable_i=0 does not abort the serializer. The frame in flight and any pending sample complete normally.
- overrun_o clears only on reset.
- Frame time is (FRAME_BITS+1)·2·BCLK_DIV clocks. At defaults this is 68 clocks, within the 128-clock window, so no overrun occurs.

## Timing
- Reset (reset_n_i=0 at an edge) clears, at that edge:
  - acc, cnt and pending;
  - FSM to IDLE;
  - all outputs to 0, including sample_o and overrun_o.
- Reset mid-frame aborts the frame immediately.
- Decimator latency: audio_i of the last window cycle t feeds sample_o and sample_vld_o, both valid in cycle t+1.
- Serializer latency:
  - FSM samples sample_vld_o at cycle t+1.
  - First data bit, the MSB with bclk low, appears in cycle t+2.
  - Rising dac_bclk_o occurs at t+2+BCLK_DIV.
- Windows are back-to-back. sample_vld_o pulses every 2^LOG2_DEC clocks while enable_i stays high.
- After enable_i rises, the first pulse comes exactly 2^LOG2_DEC clocks later.

## Test plan
- Constant level:
  - Stimulus: audio_i=0x800, defaults.
  - sample_o=0x800, with sample_vld_o every 128 clocks.
  - Serial frame is 1000_0000_0000_0000.
  - dac_lrck_o is high for 4 clocks after 64 shift clocks.
- Full scale and ramp:
  - audio_i=0xFFF gives sample_o=0xFFF, with no wrap.
  - audio_i = cnt·32 (0..4064 over the window) gives sample_o=0x7F0.
- Enable drop:
  - Drop enable_i for 10 clocks mid-window.
  - No pulse for that window.
  - The next pulse comes 128 clocks after enable_i returns.
  - The frame in flight completes bit-exact.
- Overrun:
  - Stimulus: BCLK_DIV=8, so the frame is 272 clocks.
  - The third consecutive sample sets overrun_o=1.
  - The next transmitted frame carries the newest sample.
- Back-to-back with LOG2_DEC=6 and BCLK_DIV=2:
  - The window is 64 clocks and the frame is 68 clocks.
  - Pending absorbs the backlog without overrun.
  - The exit-coincidence case is hit and loads pending first.
- Reset mid-frame:
  - Assert reset_n_i during bit 5.
  - Next cycle, all outputs are 0 and the FSM is IDLE.
  - The first post-reset pulse comes 128 clocks after release.

Source files
------------

// File: rtl/exp_audio_decim_ser.sv
// Sunsoft 5B expansion-audio output stage: box-car decimates the synth level and
// ships each averaged sample MSB-first to a serial DAC (bclk / data / latch).
module exp_audio_decim_ser #(
    parameter int DEPTH      = 12,
    parameter int LOG2_DEC   = 7,
    parameter int BCLK_DIV   = 2,
    parameter int FRAME_BITS = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic [DEPTH-1:0] audio_i,
    output logic [DEPTH-1:0] sample_o,
    output logic             sample_vld_o,
    output logic             dac_bclk_o,
    output logic             dac_data_o,
    output logic             dac_lrck_o,
    output logic             overrun_o
);

    localparam int AW = DEPTH + LOG2_DEC;
    localparam int DW = (2 * BCLK_DIV > 1) ? $clog2(2 * BCLK_DIV) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [LOG2_DEC-1:0] CNT_LAST = '1;
    localparam logic [DW-1:0]       DIV_LAST = DW'(2 * BCLK_DIV - 1);
    localparam logic [DW-1:0]       DIV_HALF = DW'(BCLK_DIV);
    localparam logic [BW-1:0]       BIT_TOP  = BW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    function automatic logic [DEPTH-1:0] avg_trunc(input logic [AW-1:0] sum);
        avg_trunc = sum[AW-1:LOG2_DEC];
    endfunction

    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DEPTH-1:0] s);
        frame_of = FRAME_BITS'(s) << (FRAME_BITS - DEPTH);
    endfunction

    logic [AW-1:0]         r_acc;
    logic [LOG2_DEC-1:0]   r_cnt;
    logic [DEPTH-1:0]      r_sample;
    logic                  r_vld;
    logic [AW-1:0]         w_sum;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [BW-1:0]         r_bit;
    logic [DW-1:0]         r_div;
    logic [DEPTH-1:0]      r_pend;
    logic                  r_pend_vld;
    logic                  r_overrun;

    logic                  w_div_end;
    logic                  w_load;
    logic                  w_load_pend;
    logic                  w_pend_wr;
    logic                  w_pend_clr;
    logic                  w_ovr_set;
    logic                  w_bclk;
    logic                  w_data;
    logic                  w_lrck;

    // acc is DEPTH+LOG2_DEC wide, so the final window sum never wraps
    assign w_sum = r_acc + AW'(audio_i);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sample <= '0;
            r_vld    <= 1'b0;
        end else if (!enable_i) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_sample <= avg_trunc(w_sum);
            r_vld    <= 1'b1;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            r_vld <= 1'b0;
        end
    end

    assign w_div_end = (r_div == DIV_LAST);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_pend = 1'b0;
        w_pend_wr   = 1'b0;
        w_pend_clr  = 1'b0;
        w_ovr_set   = 1'b0;
        w_bclk      = 1'b0;
        w_data      = 1'b0;
        w_lrck      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_vld) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end
            end
            S_SHIFT: begin
                w_bclk = (r_div >= DIV_HALF);
                w_data = r_shift[FRAME_BITS-1];
                if (w_div_end && (r_bit == '0)) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_lrck = 1'b1;
                if (w_div_end) begin
                    if (r_pend_vld) begin
                        w_state_nxt = S_SHIFT;
                        w_load      = 1'b1;
                        w_load_pend = 1'b1;
                        w_pend_clr  = 1'b1;
                    end else if (r_vld) begin
                        w_state_nxt = S_SHIFT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A sample arriving while busy parks in pending, unless it goes straight
        // into the shifter; when pending is drained the same cycle there is no loss.
        if (r_vld && (r_state != S_IDLE) && !(w_load && !w_load_pend)) begin
            w_pend_wr = 1'b1;
            w_ovr_set = r_pend_vld && !w_load_pend;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_shift    <= '0;
            r_bit      <= '0;
            r_div      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift <= w_load_pend ? frame_of(r_pend) : frame_of(r_sample);
                r_bit   <= BIT_TOP;
                r_div   <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_div_end) begin
                    r_div <= '0;
                    if (r_state == S_SHIFT) begin
                        r_shift <= r_shift << 1;
                        r_bit   <= r_bit - 1'b1;
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
            if (w_pend_wr) begin
                r_pend     <= r_sample;
                r_pend_vld <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend_vld <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign sample_o     = r_sample;
    assign sample_vld_o = r_vld;
    assign dac_bclk_o   = w_bclk;
    assign dac_data_o   = w_data;
    assign dac_lrck_o   = w_lrck;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_exp_audio_decim_ser.sv
// Directed bench for exp_audio_decim_ser: default build plus a 64-clock-window
// build and a slow-bit-clock build sharing clock, reset, enable and audio.
module tb_exp_audio_decim_ser;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [11:0] audio;

    logic [11:0] a_sample, b_sample, c_sample;
    logic        a_vld, a_bclk, a_data, a_lrck, a_ovr;
    logic        b_vld, b_bclk, b_data, b_lrck, b_ovr;
    logic        c_vld, c_bclk, c_data, c_lrck, c_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    exp_audio_decim_ser u_a (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .audio_i(audio),
        .sample_o(a_sample), .sample_vld_o(a_vld), .dac_bclk_o(a_bclk),
        .dac_data_o(a_data), .dac_lrck_o(a_lrck), .overrun_o(a_ovr)
    );

    exp_audio_decim_ser #(.LOG2_DEC(6)) u_b (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .audio_i(audio),
        .sample_o(b_sample), .sample_vld_o(b_vld), .dac_bclk_o(b_bclk),
        .dac_data_o(b_data), .dac_lrck_o(b_lrck), .overrun_o(b_ovr)
    );

    exp_audio_decim_ser #(.BCLK_DIV(8)) u_c (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .audio_i(audio),
        .sample_o(c_sample), .sample_vld_o(c_vld), .dac_bclk_o(c_bclk),
        .dac_data_o(c_data), .dac_lrck_o(c_lrck), .overrun_o(c_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_vld_a(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (a_vld !== 1'b1 && n < 400);
    endtask

    // Walks one default-build frame from the cycle after sample_vld_o; enable is
    // dropped before step off_at and restored before step on_at.
    task automatic capture_a(input int off_at, input int on_at, output logic [15:0] word,
                             output int bclk_err, output int data_err, output int lrck_n);
        int   s;
        logic d0;
        s = 0; d0 = 1'b0;
        word = '0; bclk_err = 0; data_err = 0; lrck_n = 0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (s == off_at) enable = 1'b0;
                if (s == on_at)  enable = 1'b1;
                step();
                s++;
                if (k == 0) begin
                    d0   = a_data;
                    word = {word[14:0], a_data};
                end else if (a_data !== d0) begin
                    data_err++;
                end
                if (a_bclk !== ((k >= 2) ? 1'b1 : 1'b0)) bclk_err++;
                if (a_lrck !== 1'b0) bclk_err++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            if (a_lrck === 1'b1 && a_bclk === 1'b0 && a_data === 1'b0) lrck_n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          be, de, ln;
        logic [15:0] w;
        logic [15:0] b_word, c_word;

        reset_n = 1'b0; enable = 1'b0; audio = '0;
        repeat (3) step();
        check("rst_sample", a_sample, 12'h000);
        check("rst_vld",    a_vld,  1'b0);
        check("rst_bclk",   a_bclk, 1'b0);
        check("rst_data",   a_data, 1'b0);
        check("rst_lrck",   a_lrck, 1'b0);
        check("rst_ovr",    a_ovr,  1'b0);
        check("rst_ovr_b",  b_ovr,  1'b0);
        check("rst_ovr_c",  c_ovr,  1'b0);

        // Constant mid level, first pulse timed from enable rising
        reset_n = 1'b1; enable = 1'b1; audio = 12'h800;
        wait_vld_a(n);
        check("first_pulse_lat", n, 128);
        check("const_sample", a_sample, 12'h800);
        capture_a(-1, -1, w, be, de, ln);
        check("const_frame", w, 16'h8000);
        check("const_bclk_pat", be, 0);
        check("const_data_stable", de, 0);
        check("const_lrck_clks", ln, 4);
        step();
        check("idle_lrck", a_lrck, 1'b0);
        wait_vld_a(n);
        check("const_period", n, 59);

        // Full scale
        audio = 12'hFFF;
        wait_vld_a(n);
        check("fs_period", n, 128);
        check("fs_sample", a_sample, 12'hFFF);
        capture_a(-1, -1, w, be, de, ln);
        check("fs_frame", w, 16'hFFF0);
        check("fs_bclk_pat", be, 0);
        wait_vld_a(n);
        check("fs_period2", n, 60);

        // Ramp 0..4064 in steps of 32 over one window
        for (int j = 0; j < 128; j++) begin
            audio = 12'(j * 32);
            step();
        end
        check("ramp_vld", a_vld, 1'b1);
        check("ramp_sample", a_sample, 12'h7F0);

        // Enable dropped for 10 clocks while the ramp frame is shifting
        audio = 12'h800;
        capture_a(20, 30, w, be, de, ln);
        check("endrop_frame", w, 16'h7F00);
        check("endrop_bclk_pat", be, 0);
        check("endrop_data_stable", de, 0);
        check("endrop_lrck_clks", ln, 4);
        wait_vld_a(n);
        check("endrop_next_pulse", n, 90);
        check("endrop_sample", a_sample, 12'h800);

        // Reset during bit 5 with bit clock high
        repeat (43) step();
        check("pre_rst_bclk", a_bclk, 1'b1);
        reset_n = 1'b0;
        step();
        check("midrst_sample", a_sample, 12'h000);
        check("midrst_vld",    a_vld,  1'b0);
        check("midrst_bclk",   a_bclk, 1'b0);
        check("midrst_data",   a_data, 1'b0);
        check("midrst_lrck",   a_lrck, 1'b0);
        check("midrst_ovr",    a_ovr,  1'b0);
        reset_n = 1'b1;
        wait_vld_a(n);
        check("post_rst_pulse", n, 128);

        // Overrun (slow bit clock) and back-to-back pending (64-clock window)
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        b_word = '0; c_word = '0;
        for (int t = 1; t <= 1216; t++) begin
            audio = 12'(((t - 1) / 64 + 1) * 64);
            step();
            if (t == 384) begin
                check("c_vld_s3", c_vld, 1'b1);
                check("c_sample_s3", c_sample, 12'h160);
                check("c_ovr_before", c_ovr, 1'b0);
            end
            if (t == 385) check("c_ovr_set", c_ovr, 1'b1);
            if (t == 400) check("c_latch", c_lrck, 1'b1);
            if (t == 409) check("c_bclk_hi", c_bclk, 1'b1);
            if (t >= 401 && t <= 641 && ((t - 401) % 16) == 0) c_word = {c_word[14:0], c_data};
            if (t == 1152) begin
                check("b_coinc_vld", b_vld, 1'b1);
                check("b_coinc_lrck", b_lrck, 1'b1);
                check("b_coinc_sample", b_sample, 12'h480);
                check("b_ovr_coinc", b_ovr, 1'b0);
            end
            if (t == 1155) check("b_bclk_hi", b_bclk, 1'b1);
            if (t >= 1153 && t <= 1213 && ((t - 1153) % 4) == 0) b_word = {b_word[14:0], b_data};
        end
        check("c_frame_newest", c_word, 16'h1600);
        check("b_frame_pending_first", b_word, 16'h4400);
        check("b_no_overrun", b_ovr, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
